io_bus_bridge: RTL

//  Upstream stage of the serial-IO address decoder. Avalon-MM slave on the HPS lightweight bridge
//  (window 0xFF21_0000-0xFF21_FFFF) that turns each access into one timed 16-bit IO bus cycle.
//  The cycle drives Address, IOSelect_H, ByteSelect_L, OE_L/WE_L and data to the IO chips.
//  The IO chips are the 16550 UARTs selected by the decoder. Programmable setup/strobe/hold

---
 rtl/io_bus_pkg.sv | 36 +++
 rtl/io_bus_timer.sv | 29 ++
 rtl/io_bus_bridge.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Purpose : shared types and timing constants for the HPS-to-IO-bus bridge.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: FSM state enum, default phase lengths, ready-timeout constants and
//           a helper that sizes the shared phase down-counter.
package io_bus_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } io_state_t;

   localparam int IO_SETUP_DEFAULT  = 1;
   localparam int IO_STROBE_DEFAULT = 3;
   localparam int IO_HOLD_DEFAULT   = 1;

   // Returned on a read whose strobe ran out of ready-wait budget.
   localparam logic [15:0] IO_TIMEOUT_DATA = 16'hDEAD;
   // Extra strobe cycles allowed while waiting for the IO chip to assert ready.
   localparam int IO_READY_TIMEOUT = 255;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counter holds N-1 for the longest phase N; keep at least one bit.
   function automatic int cnt_width(input int max_len);
      return (max_len > 1) ? $clog2(max_len) : 1;
   endfunction

endpackage

// File: rtl/io_bus_timer.sv
// Purpose : shared phase down-counter; loaded with N-1 on phase entry, flags zero.
// Latency : load takes effect on the next rising edge; zero is combinational from the count.
// Backpr. : none; the counter parks at zero until reloaded.
// Ports   : clk, rst (async active-high), load/load_val (reload request and value),
//           count (current value), zero (count == 0).
module io_bus_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/io_bus_bridge.sv
// Purpose : Avalon-MM slave (HPS lightweight window 0xFF21_xxxx) that runs each access as one
//           timed 16-bit IO bus cycle (SETUP -> STROBE -> HOLD) towards the 16550 UART chips.
// Latency : request seen in IDLE at cycle 0 -> waitrequest low at cycle 1+SETUP+STROBE+HOLD.
// Backpr. : avs_waitrequest stays high except for the single DONE cycle; requests only taken in IDLE.
// Ports   : Clock, Reset_H (async active-high); avs_* Avalon slave (address/read/write/
//           writedata/byteenable in, readdata/waitrequest out); Address, IOSelect_H,
//           ByteSelect_L, OE_L, WE_L, DataOut to the IO bus; DataIn from the IO bus.
// Option  : IO_BUS_READY_EN adds IOReady_H (2-flop synchronised); STROBE then stretches until
//           ready, for at most IO_READY_TIMEOUT extra cycles, and a timed-out read returns
//           IO_TIMEOUT_DATA.
module io_bus_bridge
   import io_bus_pkg::*;
#(
   parameter int SETUP_CYCLES  = IO_SETUP_DEFAULT,
   parameter int STROBE_CYCLES = IO_STROBE_DEFAULT,
   parameter int HOLD_CYCLES   = IO_HOLD_DEFAULT
) (
   input  logic        Clock,
   input  logic        Reset_H,
   input  logic [15:0] avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [15:0] avs_writedata,
   input  logic [1:0]  avs_byteenable,
   output logic [15:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic [15:0] Address,
   output logic        IOSelect_H,
   output logic        ByteSelect_L,
   output logic        OE_L,
   output logic        WE_L,
   output logic [15:0] DataOut,
   input  logic [15:0] DataIn
`ifdef IO_BUS_READY_EN
   ,
   input  logic        IOReady_H
`endif
);

`ifdef IO_BUS_READY_EN
   localparam int STROBE_MAX = STROBE_CYCLES + IO_READY_TIMEOUT;
`else
   localparam int STROBE_MAX = STROBE_CYCLES;
`endif
   localparam int TW = cnt_width(max3(SETUP_CYCLES, STROBE_MAX, HOLD_CYCLES));

   localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] STROBE_LD = TW'(STROBE_MAX - 1);
   localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES - 1);

   io_state_t       state, state_nxt;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic [TW-1:0]   tmr_count;
   logic            tmr_zero;
   logic            accept;
   logic            strobe_exit;
   logic            strobe_timeout;

   // Latched request; held for the whole bus cycle regardless of what the master does.
   logic [15:0]     addr_q;
   logic [15:0]     wdata_q;
   logic            be_hi_q;
   logic            wr_q;
   logic [15:0]     rdata_q;

   io_bus_timer #(.W(TW)) u_timer (
      .clk      (Clock),
      .rst      (Reset_H),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

`ifdef IO_BUS_READY_EN
   logic rdy_meta, rdy_sync;

   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         rdy_meta <= 1'b0;
         rdy_sync <= 1'b0;
      end else begin
         rdy_meta <= IOReady_H;
         rdy_sync <= rdy_meta;
      end
   end

   // The counter is loaded with STROBE_CYCLES-1+timeout, so once it has counted down to
   // IO_READY_TIMEOUT the minimum strobe width has elapsed and ready may end the phase.
   assign strobe_exit    = tmr_zero | (rdy_sync & (tmr_count <= TW'(IO_READY_TIMEOUT)));
   assign strobe_timeout = tmr_zero & ~rdy_sync;

   logic unused_ok;
   assign unused_ok = avs_byteenable[0];
`else
   assign strobe_exit    = tmr_zero;
   assign strobe_timeout = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{avs_byteenable[0], tmr_count};
`endif

   assign accept = (state == IDLE) & (avs_read | avs_write);

   // State register; async reset drops strobes the instant Reset_H rises.
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, plus timer reload on entry to each timed phase.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SETUP;
               tmr_load  = 1'b1;
               tmr_val   = SETUP_LD;
            end
         end
         SETUP: begin
            if (tmr_zero) begin
               state_nxt = STROBE;
               tmr_load  = 1'b1;
               tmr_val   = STROBE_LD;
            end
         end
         STROBE: begin
            if (strobe_exit) begin
               state_nxt = HOLD;
               tmr_load  = 1'b1;
               tmr_val   = HOLD_LD;
            end
         end
         HOLD: begin
            if (tmr_zero) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the current state and the latched request.
   always_comb begin
      avs_waitrequest = (state != DONE);
      IOSelect_H      = (state == SETUP) | (state == STROBE) | (state == HOLD);
      ByteSelect_L    = IOSelect_H ? ~be_hi_q : 1'b1;
      OE_L            = ~((state == STROBE) & ~wr_q);
      WE_L            = ~((state == STROBE) & wr_q);
      Address         = addr_q;
      DataOut         = wdata_q;
      avs_readdata    = rdata_q;
   end

   // Request capture. Write wins when read and write are raised together.
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_hi_q <= 1'b0;
         wr_q    <= 1'b0;
      end else if (accept) begin
         addr_q  <= avs_address;
         be_hi_q <= avs_byteenable[1];
         wr_q    <= avs_write;
         if (avs_write) begin
            wdata_q <= avs_writedata;
         end
      end
   end

   // Read data is captured on the last strobe cycle and held until the next read.
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         rdata_q <= '0;
      end else if ((state == STROBE) && strobe_exit && !wr_q) begin
         rdata_q <= strobe_timeout ? IO_TIMEOUT_DATA : DataIn;
      end
   end

endmodule
